// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common to urx and utx),
// default bit period and frame geometry.
package uart_pkg;

  localparam int DEF_CLKS_PER_BIT = 104;
  localparam int DATA_BITS        = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for an asynchronous level input; both flops reset
// to 1 so an idle-high line never looks like an edge on reset release.
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync_p0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b1;
      q       <= 1'b1;
    end else begin
      sync_p0 <= d;
      q       <= sync_p0;
    end
  end

endmodule

// File: rtl/urx.sv
// 8N1 UART receiver: mid-bit sampling deframer feeding a single-entry
// holding register with framing-error, break and overrun reporting.
module urx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dataout,
  output logic                 rvalid,
  input  logic                 rack,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_END = CW'((CLKS_PER_BIT >> 1) - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_END  = IW'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_e          state, state_nx;
  logic [CW-1:0]        cnt, cnt_nx;
  logic [IW-1:0]        idx, idx_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx;
  logic                 good, bad;

  rx_sync u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      shreg <= shreg_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    idx_nx   = idx;
    shreg_nx = shreg;
    good     = 1'b0;
    bad      = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        if (!rx_s) state_nx = ST_START;
      end
      ST_START: begin
        // A start bit that is gone by mid-bit was a glitch.
        if (cnt == HALF_END) begin
          cnt_nx   = '0;
          idx_nx   = '0;
          state_nx = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt == BIT_END) begin
          cnt_nx        = '0;
          shreg_nx[idx] = rx_s;
          idx_nx        = idx + 1'b1;
          if (idx == IDX_END) state_nx = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt == BIT_END) begin
          cnt_nx = '0;
          if (rx_s) begin
            good     = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            bad      = 1'b1;
            state_nx = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // Hold off until the line returns high so a break yields one error.
        cnt_nx = '0;
        if (rx_s) state_nx = ST_IDLE;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dataout   <= '0;
      rvalid    <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      busy      <= (state != ST_IDLE);
      frame_err <= bad;
      overrun   <= good && rvalid && !rack;
      if (good && (!rvalid || rack)) begin
        dataout <= shreg;
        rvalid  <= 1'b1;
      end else if (rack) begin
        rvalid  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/urx.md
# urx

UART receiver for the USB pass-through path: oversamples the serial line from the USB-UART bridge, deframes 8N1 characters (1 start, 8 data LSB-first, 1 stop) and presents each byte on a ready/valid-style holding register. Sits upstream of the FPGA logic that loops or processes bytes before they return to the host through the transmitter. Detects framing errors, line breaks and overruns.

## Interface
- `CLKS_PER_BIT`, default 104, `clk` cycles per bit (12 MHz / 115200); legal range ≥ 4.
- `clk`, input, 1, system clock; all logic on rising edge.
- `rst`, input, 1, asynchronous, active-low reset.
- `rx`, input, 1, asynchronous serial line; idles high.
- `dataout`, output, 8, last accepted byte; held stable while `rvalid` = 1.
- `rvalid`, output, 1, level; 1 = `dataout` holds an unconsumed byte.
- `rack`, input, 1, consumer acknowledge; clears `rvalid` when sampled high with `rvalid` = 1.
- `busy`, output, 1, 1 while a frame is in progress (any state other than IDLE).
- `frame_err`, output, 1, one-cycle pulse: stop bit sampled 0.
- `overrun`, output, 1, one-cycle pulse: good byte completed while `rvalid` = 1 and no `rack`.

## Operation
- `rx` passes through a 2-flop synchronizer (`rx_s`, reset value 1) before any use.
- Bit counter: width $clog2(CLKS_PER_BIT); half-bit = CLKS_PER_BIT >> 1.
- States: IDLE, START, DATA, STOP, BREAK.
  - IDLE: `rx_s` = 0 → START, clear counter.
  - START: after half-bit cycles sample `rx_s`; 0 → DATA (bit index 0); 1 → IDLE (glitch, no output).
  - DATA: every CLKS_PER_BIT cycles sample `rx_s` into shift register at index (LSB first); after index 7 → STOP.
  - STOP: after CLKS_PER_BIT cycles sample `rx_s`. 1 → good byte, → IDLE. 0 → `frame_err` pulse, byte discarded, → BREAK.
  - BREAK: wait for `rx_s` = 1, then → IDLE (prevents re-triggering on a held-low line).
- Good byte, `rvalid` = 0 or `rack` = 1 same cycle: load `dataout`, `rvalid` = 1.
- Good byte, `rvalid` = 1 and `rack` = 0: new byte dropped, `dataout` unchanged, `overrun` pulse.
- `rack` with `rvalid` = 0: ignored.
- Reset values: `dataout` = 8'h00, `rvalid` = 0, `busy` = 0, `frame_err` = 0, `overrun` = 0, state IDLE, counters 0.
- Reset mid-frame aborts immediately. The partial byte is never delivered. After release, reception restarts at the next `rx_s` low.

## Timing
- Pin → `rx_s`: 2 cycles.
- T0 = first IDLE cycle with `rx_s` = 0.
- Start sample at T0 + half-bit.
- Data bit i sampled at T0 + half-bit + (i+1)·CLKS_PER_BIT.
- Stop sample at T0 + half-bit + 9·CLKS_PER_BIT.
- `rvalid` / `frame_err` / `overrun` assert on the cycle after the stop sample.
- Back-to-back frames: IDLE is re-entered right after the stop sample. A start edge arriving half a bit later is caught with no lost character.
- `rack` → `rvalid` low on the next edge.
- `busy` is registered; it follows state with 1-cycle delay.

## Structure
- Shared package `uart_pkg`:
  - state encoding constants shared with `utx`;
  - default `CLKS_PER_BIT`;
  - frame constants (DATA_BITS = 8).
- Sub-module `rx_sync`: 2-flop synchronizer, reset to 1. It is reusable for other async inputs.

## Test plan
All scenarios use CLKS_PER_BIT = 8.
- Send 8'hA5 frame, `rack` tied 0 → `dataout` = 8'hA5 and `rvalid` = 1 at T0 + 4 + 72 + 1; `frame_err` = 0.
- Send 8'h3C then 8'hC3 back-to-back, `rack` pulsed after first → both bytes delivered in order; no `overrun`.
- Send 8'h11 then 8'h22, `rack` held 0 → `dataout` stays 8'h11; one `overrun` pulse at the second frame's stop.
- Drive `rx` low for 3 cycles only → return to IDLE; `rvalid`, `frame_err` stay 0; `busy` drops.
- Hold `rx` low 30 bit-times → single `frame_err` pulse; no `rvalid`. Release and send 8'h5A → 8'h5A received.
- Assert `rst` low during data bit 4 of 8'hFF → all outputs at reset values. Send 8'h81 after release → 8'h81 received cleanly.
